// File: rtl/rgbd_vo_reg_file.sv
// rtl/rgbd_vo_reg_file.sv - RGB-D VO configuration register bank with a valid/ready request/response channel.
// Optional frame-synchronous shadowing of all fields except DISABLE: define RGBDVO_REG_SHADOW_EN.
module rgbd_vo_reg_file #(
  parameter int unsigned ADDR_BW       = 32,
  parameter int unsigned DATA_BW       = 64,
  parameter int unsigned H_SIZE_RST    = 640,
  parameter int unsigned V_SIZE_RST    = 480,
  parameter int unsigned DEPTH_MAX_RST = 20000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_write,
  input  logic [ADDR_BW-1:0] i_req_addr,
  input  logic [DATA_BW-1:0] i_req_wdata,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [DATA_BW-1:0] o_rsp_rdata,
  output logic               o_rsp_err,
  input  logic               i_frame_start,
  output logic               o_cfg_update,
  output logic               o_disable,
  output logic [9:0]         o_h_size,
  output logic [9:0]         o_v_size,
  output logic [34:0]        o_fx,
  output logic [34:0]        o_fy,
  output logic [34:0]        o_cx,
  output logic [34:0]        o_cy,
  output logic [15:0]        o_depth_max,
  output logic [15:0]        o_depth_min,
  output logic [31:0]        o_reserved
);

  localparam int unsigned IW = 35;

  logic               r_rsp_valid;
  logic [DATA_BW-1:0] r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_cfg_update;
  logic               r_disable;

  // Programmed values: the shadow copies when shadowing is on, the active fields otherwise.
  logic [9:0]    r_cfg_h_size, r_cfg_v_size;
  logic [IW-1:0] r_cfg_fx, r_cfg_fy, r_cfg_cx, r_cfg_cy;
  logic [15:0]   r_cfg_depth_max, r_cfg_depth_min;
  logic [31:0]   r_cfg_reserved;

  logic               w_req_ready;
  logic               w_accept;
  logic               w_addr_ok;
  logic               w_wr;
  logic [3:0]         w_sel;
  logic [DATA_BW-1:0] w_rd_data;
  logic               w_unused;

  assign w_req_ready = !r_rsp_valid || i_rsp_ready;
  assign w_accept    = i_req_valid && w_req_ready;
  assign w_addr_ok   = (i_req_addr < ADDR_BW'(10));
  assign w_sel       = i_req_addr[3:0];
  assign w_wr        = w_accept && i_req_write && w_addr_ok;

  always_comb begin
    w_rd_data = '0;
    if (w_addr_ok) begin
      case (w_sel)
        4'd0:    w_rd_data = DATA_BW'(r_disable);
        4'd1:    w_rd_data = DATA_BW'(r_cfg_h_size);
        4'd2:    w_rd_data = DATA_BW'(r_cfg_v_size);
        4'd3:    w_rd_data = {{(DATA_BW-IW){r_cfg_fx[IW-1]}}, r_cfg_fx};
        4'd4:    w_rd_data = {{(DATA_BW-IW){r_cfg_fy[IW-1]}}, r_cfg_fy};
        4'd5:    w_rd_data = {{(DATA_BW-IW){r_cfg_cx[IW-1]}}, r_cfg_cx};
        4'd6:    w_rd_data = {{(DATA_BW-IW){r_cfg_cy[IW-1]}}, r_cfg_cy};
        4'd7:    w_rd_data = DATA_BW'(r_cfg_depth_max);
        4'd8:    w_rd_data = DATA_BW'(r_cfg_depth_min);
        4'd9:    w_rd_data = DATA_BW'(r_cfg_reserved);
        default: w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_rdata <= i_req_write ? '0 : w_rd_data;
      r_rsp_err   <= !w_addr_ok;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_disable <= 1'b1;
    end else if (w_wr && w_sel == 4'd0) begin
      r_disable <= i_req_wdata[0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cfg_h_size    <= 10'(H_SIZE_RST);
      r_cfg_v_size    <= 10'(V_SIZE_RST);
      r_cfg_fx        <= '0;
      r_cfg_fy        <= '0;
      r_cfg_cx        <= '0;
      r_cfg_cy        <= '0;
      r_cfg_depth_max <= 16'(DEPTH_MAX_RST);
      r_cfg_depth_min <= '0;
      r_cfg_reserved  <= '0;
    end else if (w_wr) begin
      case (w_sel)
        4'd1:    r_cfg_h_size    <= i_req_wdata[9:0];
        4'd2:    r_cfg_v_size    <= i_req_wdata[9:0];
        4'd3:    r_cfg_fx        <= i_req_wdata[IW-1:0];
        4'd4:    r_cfg_fy        <= i_req_wdata[IW-1:0];
        4'd5:    r_cfg_cx        <= i_req_wdata[IW-1:0];
        4'd6:    r_cfg_cy        <= i_req_wdata[IW-1:0];
        4'd7:    r_cfg_depth_max <= i_req_wdata[15:0];
        4'd8:    r_cfg_depth_min <= i_req_wdata[15:0];
        4'd9:    r_cfg_reserved  <= i_req_wdata[31:0];
        default: ;
      endcase
    end
  end

`ifdef RGBDVO_REG_SHADOW_EN
  logic [9:0]    r_act_h_size, r_act_v_size;
  logic [IW-1:0] r_act_fx, r_act_fy, r_act_cx, r_act_cy;
  logic [15:0]   r_act_depth_max, r_act_depth_min;
  logic [31:0]   r_act_reserved;

  // A write landing with the frame pulse is not seen here; it waits for the next frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_act_h_size    <= 10'(H_SIZE_RST);
      r_act_v_size    <= 10'(V_SIZE_RST);
      r_act_fx        <= '0;
      r_act_fy        <= '0;
      r_act_cx        <= '0;
      r_act_cy        <= '0;
      r_act_depth_max <= 16'(DEPTH_MAX_RST);
      r_act_depth_min <= '0;
      r_act_reserved  <= '0;
    end else if (i_frame_start) begin
      r_act_h_size    <= r_cfg_h_size;
      r_act_v_size    <= r_cfg_v_size;
      r_act_fx        <= r_cfg_fx;
      r_act_fy        <= r_cfg_fy;
      r_act_cx        <= r_cfg_cx;
      r_act_cy        <= r_cfg_cy;
      r_act_depth_max <= r_cfg_depth_max;
      r_act_depth_min <= r_cfg_depth_min;
      r_act_reserved  <= r_cfg_reserved;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cfg_update <= 1'b0;
    else       r_cfg_update <= i_frame_start || (w_wr && w_sel == 4'd0);
  end

  assign o_h_size    = r_act_h_size;
  assign o_v_size    = r_act_v_size;
  assign o_fx        = r_act_fx;
  assign o_fy        = r_act_fy;
  assign o_cx        = r_act_cx;
  assign o_cy        = r_act_cy;
  assign o_depth_max = r_act_depth_max;
  assign o_depth_min = r_act_depth_min;
  assign o_reserved  = r_act_reserved;
  assign w_unused    = &{1'b0, i_req_wdata[DATA_BW-1:IW]};
`else
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_cfg_update <= 1'b0;
    else       r_cfg_update <= w_wr;
  end

  assign o_h_size    = r_cfg_h_size;
  assign o_v_size    = r_cfg_v_size;
  assign o_fx        = r_cfg_fx;
  assign o_fy        = r_cfg_fy;
  assign o_cx        = r_cfg_cx;
  assign o_cy        = r_cfg_cy;
  assign o_depth_max = r_cfg_depth_max;
  assign o_depth_min = r_cfg_depth_min;
  assign o_reserved  = r_cfg_reserved;
  assign w_unused    = &{1'b0, i_frame_start, i_req_wdata[DATA_BW-1:IW]};
`endif

  assign o_req_ready  = w_req_ready;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_rdata  = r_rsp_rdata;
  assign o_rsp_err    = r_rsp_err;
  assign o_cfg_update = r_cfg_update;
  assign o_disable    = r_disable;

endmodule

// File: tb/tb_rgbd_vo_reg_file.sv
// tb/tb_rgbd_vo_reg_file.sv - directed self-checking bench for rgbd_vo_reg_file.
module tb_rgbd_vo_reg_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_write, i_rsp_ready, i_frame_start;
  logic [31:0] i_req_addr;
  logic [63:0] i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err, o_cfg_update, o_disable;
  logic [63:0] o_rsp_rdata;
  logic [9:0]  o_h_size, o_v_size;
  logic [34:0] o_fx, o_fy, o_cx, o_cy;
  logic [15:0] o_depth_max, o_depth_min;
  logic [31:0] o_reserved;

  int total = 0;
  int bad   = 0;

  rgbd_vo_reg_file dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_write(i_req_write),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .i_frame_start(i_frame_start), .o_cfg_update(o_cfg_update),
    .o_disable(o_disable), .o_h_size(o_h_size), .o_v_size(o_v_size),
    .o_fx(o_fx), .o_fy(o_fy), .o_cx(o_cx), .o_cy(o_cy),
    .o_depth_max(o_depth_max), .o_depth_min(o_depth_min), .o_reserved(o_reserved)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request with i_rsp_ready=1; returns the response sampled the negedge after accept.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output logic upd);
    int n;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr; i_req_wdata = wd; i_rsp_ready = 1'b1;
    n = 0;
    while (!o_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("req_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    i_req_valid = 1'b0;
    check("xfer_rsp_valid", o_rsp_valid, 64'd1);
    rd = o_rsp_rdata; er = o_rsp_err; upd = o_cfg_update;
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    i_frame_start = 1'b1;
    @(negedge clk);
    i_frame_start = 1'b0;
  endtask

  logic [63:0] rd;
  logic        er, upd;
  logic [63:0] rst_vals [10] = '{64'd1, 64'd640, 64'd480, 64'd0, 64'd0, 64'd0, 64'd0, 64'd20000, 64'd0, 64'd0};
  logic [31:0] s_addr [4]    = '{32'd2, 32'd7, 32'd0, 32'd8};
  logic [63:0] s_exp  [4]    = '{64'd480, 64'd20000, 64'd1, 64'd0};

  initial begin
    rst = 1'b1;
    i_req_valid = 0; i_req_write = 0; i_req_addr = 0; i_req_wdata = 0;
    i_rsp_ready = 1; i_frame_start = 0;
    #12;
    check("rst_rsp_valid", o_rsp_valid, 64'd0);
    check("rst_cfg_update", o_cfg_update, 64'd0);
    check("rst_disable", o_disable, 64'd1);
    check("rst_h_size", o_h_size, 64'd640);
    check("rst_depth_max", o_depth_max, 64'd20000);
    check("rst_req_ready", o_req_ready, 64'd1);
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 10; a++) begin
      xfer(1'b0, a, 64'd0, rd, er, upd);
      check($sformatf("rst_read_%0d", a), rd, rst_vals[a]);
      check($sformatf("rst_read_err_%0d", a), er, 64'd0);
    end

    xfer(1'b1, 32'd12, 64'h1234, rd, er, upd);
    check("bad_addr_err", er, 64'd1);
    check("bad_addr_rdata", rd, 64'd0);
    check("bad_addr_upd", upd, 64'd0);
    for (int a = 0; a < 10; a++) begin
      xfer(1'b0, a, 64'd0, rd, er, upd);
      check($sformatf("after_bad_%0d", a), rd, rst_vals[a]);
      check($sformatf("after_bad_upd_%0d", a), upd, 64'd0);
    end
    xfer(1'b0, 32'hFFFF_FFFF, 64'd0, rd, er, upd);
    check("bad_read_err", er, 64'd1);
    check("bad_read_rdata", rd, 64'd0);

    // Backpressure: hold the response, then stream reads back to back.
    @(negedge clk);
    i_req_valid = 1; i_req_write = 0; i_req_addr = 1; i_rsp_ready = 0;
    @(negedge clk);
    check("hold_valid0", o_rsp_valid, 64'd1);
    check("hold_rdata0", o_rsp_rdata, 64'd640);
    i_req_addr = s_addr[0];
    for (int c = 0; c < 5; c++) begin
      check("hold_req_ready", o_req_ready, 64'd0);
      check("hold_valid", o_rsp_valid, 64'd1);
      check("hold_rdata", o_rsp_rdata, 64'd640);
      @(negedge clk);
    end
    i_rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      i_req_addr = s_addr[i];
      @(negedge clk);
      check($sformatf("stream_valid_%0d", i), o_rsp_valid, 64'd1);
      check($sformatf("stream_rdata_%0d", i), o_rsp_rdata, s_exp[i]);
    end
    i_req_valid = 0;
    @(negedge clk);
    check("stream_drained", o_rsp_valid, 64'd0);

    xfer(1'b1, 32'd3, 64'h4_0000_0000, rd, er, upd);
    check("fx_wr_rdata", rd, 64'd0);
    check("fx_wr_err", er, 64'd0);
`ifdef RGBDVO_REG_SHADOW_EN
    check("fx_wr_upd", upd, 64'd0);
    check("fx_not_active", o_fx, 64'd0);
    pulse_frame();
`else
    check("fx_wr_upd", upd, 64'd1);
`endif
    check("fx_active", o_fx, 64'h4_0000_0000);
    xfer(1'b0, 32'd3, 64'd0, rd, er, upd);
    check("fx_sext", rd, 64'hFFFF_FFFC_0000_0000);

    xfer(1'b1, 32'd8, 64'hFFFF_FFFF_FFFF_1234, rd, er, upd);
    xfer(1'b0, 32'd8, 64'd0, rd, er, upd);
    check("depth_min_trunc", rd, 64'h1234);
    xfer(1'b1, 32'd9, 64'hAAAA_BBBB_CCCC_DDDD, rd, er, upd);
    xfer(1'b0, 32'd9, 64'd0, rd, er, upd);
    check("reserved_trunc", rd, 64'hCCCC_DDDD);

    xfer(1'b1, 32'd0, 64'd0, rd, er, upd);
    check("disable_wr_upd", upd, 64'd1);
    check("disable_active", o_disable, 64'd0);

`ifdef RGBDVO_REG_SHADOW_EN
    xfer(1'b1, 32'd1, 64'd320, rd, er, upd);
    check("h_wr_upd", upd, 64'd0);
    check("h_still_640", o_h_size, 64'd640);
    xfer(1'b0, 32'd1, 64'd0, rd, er, upd);
    check("h_read_shadow", rd, 64'd320);
    pulse_frame();
    check("h_after_frame", o_h_size, 64'd320);
    check("frame_upd", o_cfg_update, 64'd1);
    @(negedge clk);
    check("frame_upd_once", o_cfg_update, 64'd0);
    @(negedge clk);
    i_frame_start = 1; i_req_valid = 1; i_req_write = 1; i_req_addr = 2; i_req_wdata = 240; i_rsp_ready = 1;
    @(negedge clk);
    i_frame_start = 0; i_req_valid = 0;
    check("v_same_cycle", o_v_size, 64'd480);
    @(negedge clk);
    check("v_wait", o_v_size, 64'd480);
    pulse_frame();
    check("v_next_frame", o_v_size, 64'd240);
`else
    pulse_frame();
    check("frame_ignored_upd", o_cfg_update, 64'd0);
    xfer(1'b1, 32'd1, 64'd320, rd, er, upd);
    check("h_wr_upd", upd, 64'd1);
    check("h_active", o_h_size, 64'd320);
    @(negedge clk);
    check("h_upd_once", o_cfg_update, 64'd0);
`endif

    // Reset with a response pending.
    @(negedge clk);
    i_req_valid = 1; i_req_write = 0; i_req_addr = 0; i_rsp_ready = 0;
    @(negedge clk);
    i_req_valid = 0;
    check("pend_valid", o_rsp_valid, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", o_rsp_valid, 64'd0);
    check("mid_rst_h_size", o_h_size, 64'd640);
    check("mid_rst_disable", o_disable, 64'd1);
    check("mid_rst_fx", o_fx, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, 32'd1, 64'd0, rd, er, upd);
    check("post_rst_h_read", rd, 64'd640);
    xfer(1'b0, 32'd3, 64'd0, rd, er, upd);
    check("post_rst_fx_read", rd, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgbd_vo_reg_file.md
Name: rgbd_vo_reg_file

Overview:
- Register-bank responder for the RGB-D VO configuration map: DISABLE, H_SIZE, V_SIZE, FX, FY, CX, CY, DEPTH_MAX, DEPTH_MIN, RESERVED at word addresses 0..9.
- Accepts read and write requests from the host-side bus master over a valid/ready request channel, and returns responses on a valid/ready response channel.
- Drives the active configuration fields into the VO datapath: point-cloud projection, depth filtering and frame sizing.

Parameters:
- ADDR_BW, 32, request address width (matches the RegAddr enum width).
- DATA_BW, 64, read/write data width (matches MATRIX_BW).
- H_SIZE_RST, 640, reset value of H_SIZE.
- V_SIZE_RST, 480, reset value of V_SIZE.
- DEPTH_MAX_RST, 20000, reset value of DEPTH_MAX.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  1  request valid.
- o_req_ready  out  1  request ready.
- i_req_write  in  1  1 = write, 0 = read.
- i_req_addr  in  ADDR_BW  register word address.
- i_req_wdata  in  DATA_BW  write data.
- o_rsp_valid  out  1  response valid.
- i_rsp_ready  in  1  response ready.
- o_rsp_rdata  out  DATA_BW  read data (0 for writes and errors).
- o_rsp_err  out  1  address-decode error.
- i_frame_start  in  1  one-cycle pulse at the start of each frame.
- o_cfg_update  out  1  one-cycle pulse when the active config changes.
- o_disable  out  1  active DISABLE.
- o_h_size, o_v_size  out  10  active frame size.
- o_fx, o_fy, o_cx, o_cy  out  35  active intrinsics (Q10.24 plus sign, two's complement).
- o_depth_max, o_depth_min  out  16  active depth thresholds.
- o_reserved  out  32  scratch register.

Behaviour:
- Reset values:
  - DISABLE=1, H_SIZE=H_SIZE_RST, V_SIZE=V_SIZE_RST, FX/FY/CX/CY=0, DEPTH_MAX=DEPTH_MAX_RST, DEPTH_MIN=0, RESERVED=0.
  - Shadow copies reset to the same values.
  - o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0, o_cfg_update=0.
- Request acceptance:
  - A request is accepted when i_req_valid && o_req_ready.
  - o_req_ready = !o_rsp_valid || i_rsp_ready. At most one response is outstanding.
  - Back-to-back accepts are possible at one per cycle while i_rsp_ready=1.
- Response timing:
  - Latency is 1: o_rsp_valid rises the cycle after accept.
  - The response holds stable until i_rsp_ready=1.
  - If no new accept occurs in the same cycle, o_rsp_valid clears.
- Decode:
  - Addresses 0..9 are valid.
  - Address > 9 returns o_rsp_err=1 and rdata=0; the write is dropped and no register changes.
- Writes:
  - Write data is truncated to the low field-width bits.
  - A write response has rdata=0 and err=0.
- Reads:
  - FX/FY/CX/CY are sign-extended from bit 34 to DATA_BW.
  - All other fields are zero-extended.
  - A read returns the value visible per the Optional Feature below.
- DISABLE is never shadowed: a write takes effect on o_disable the cycle after accept, in both build modes.
- Reset mid-transaction: the pending response is dropped, o_rsp_valid=0, and all registers return to their reset values.

Optional Feature:
- Macro: RGBDVO_REG_SHADOW_EN.
- Defined:
  - Writes to all fields except DISABLE update shadow registers only.
  - On i_frame_start, every active field loads from its shadow, and o_cfg_update pulses the following cycle.
  - Reads return shadow values.
  - Write accepted in the same cycle as i_frame_start: active loads the pre-write shadow, and the new value applies at the next i_frame_start.
  - A DISABLE write also pulses o_cfg_update.
- Undefined:
  - No shadow registers; writes update the active field the cycle after accept.
  - Reads return active values.
  - i_frame_start is ignored.
  - o_cfg_update pulses the cycle after every accepted, non-error write.

Test Plan:
- Reset, then read addresses 0..9 -> responses 1, 640, 480, 0, 0, 0, 0, 20000, 0, 0; err=0 throughout.
- Write FX=0x4_0000_0000 (bit 34 set), then read FX -> rdata=0xFFFF_FFFC_0000_0000; o_fx=35'h4_0000_0000 once active.
- Write address 12 -> err=1, rdata=0; read back all registers -> unchanged; o_cfg_update stays 0.
- Hold i_rsp_ready=0 for 5 cycles after a read -> o_req_ready=0, and o_rsp_valid/rdata remain stable. Then stream 4 reads with i_rsp_ready=1 -> 4 consecutive responses, one per cycle.
- SHADOW_EN: write H_SIZE=320 -> o_h_size stays 640; pulse i_frame_start -> o_h_size=320 next cycle and o_cfg_update pulses once. Write V_SIZE=240 in the same cycle as i_frame_start -> o_v_size stays 480 until the next frame start.
- Assert i_rst while a response is pending -> o_rsp_valid=0 immediately; post-reset read of H_SIZE returns 640.
